word_memory_bank: RTL

- Parametrised, clocked successor to the single-byte store latch.
- Holds DEPTH words of WIDTH bits, with addressed writes, registered reads and per-entry valid flags.
- A sequenced bulk-clear engine wipes the bank.
- Sits between datapath registers and the display/control logic as a small scratch store.

---
 rtl/word_memory_bank.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/word_memory_bank.sv
// word_memory_bank: DEPTH x WIDTH scratch store with addressed writes, registered reads,
// per-entry valid flags and a sequenced bulk-clear engine. Optional parity: WORD_MEMORY_PARITY_EN.
module word_memory_bank #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  data,
  input  logic              store,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              clear,
  input  logic              inj_err,
  output logic [WIDTH-1:0]  memory,
  output logic              rd_valid,
  output logic [DEPTH-1:0]  entry_valid,
  output logic              busy,
  output logic              parity_err
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  // Widened by one bit so DEPTH == 2**ADDR_W still fits the compare.
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic idle;
  logic wr_in_range;
  logic rd_in_range;
  logic wr_en;
  logic bypass;

  assign idle        = (state_q == S_IDLE);
  assign wr_in_range = ({1'b0, waddr} < DEPTH_W);
  assign rd_in_range = ({1'b0, raddr} < DEPTH_W);
  // A clear request in the same cycle takes priority and drops the write.
  assign wr_en       = idle && store && !clear && wr_in_range;
  assign bypass      = wr_en && (waddr == raddr);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mem_d    = mem_q;
    valid_d  = valid_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rd_en) begin
          rvalid_d = 1'b1;
          if (!rd_in_range) begin
            rdata_d = '0;
          end else if (bypass) begin
            rdata_d = data;
          end else begin
            rdata_d = mem_q[raddr];
          end
        end
        if (clear) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end else if (wr_en) begin
          mem_d[waddr]   = data;
          valid_d[waddr] = 1'b1;
        end
      end
      S_CLEAR: begin
        mem_d[idx_q]   = '0;
        valid_d[idx_q] = 1'b0;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the storage array is reset along with the control state, since every entry must read 0 after reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      valid_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign memory      = rdata_q;
  assign rd_valid    = rvalid_q;
  assign entry_valid = valid_q;
  assign busy        = (state_q == S_CLEAR);

`ifdef WORD_MEMORY_PARITY_EN
  logic par_q [DEPTH];
  logic par_d [DEPTH];
  logic perr_q, perr_d;

  // Stored bit is even parity of the word, inverted when the inject hook is set.
  always_comb begin
    par_d  = par_q;
    perr_d = 1'b0;
    if (idle) begin
      if (rd_en && rd_in_range && !bypass) begin
        perr_d = (^mem_q[raddr]) != par_q[raddr];
      end
      if (wr_en) begin
        par_d[waddr] = (^data) ^ inj_err;
      end
    end else begin
      par_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        par_q[i] <= 1'b0;
      end
    end else begin
      perr_q <= perr_d;
      for (int i = 0; i < DEPTH; i++) begin
        par_q[i] <= par_d[i];
      end
    end
  end

  assign parity_err = perr_q;
`else
  logic unused_inj_err;
  assign unused_inj_err = inj_err;
  assign parity_err     = 1'b0;
`endif

endmodule
